// File: rtl/fb_burst_reader.sv
// Wishbone burst master streaming a framebuffer from SDRAM into a pixel FIFO write port.
// Optional double buffering is enabled by defining FB_DOUBLE_BUFFER_EN.
module fb_burst_reader #(
    parameter int unsigned HDISP       = 800,
    parameter int unsigned VDISP       = 480,
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned DEPTH_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [31:0]            fb_base0,
    input  logic [31:0]            fb_base1,
    input  logic                   swap_req,
    input  logic [DEPTH_WIDTH:0]   fifo_free,
    output logic                   fifo_write,
    output logic [31:0]            fifo_wdata,
    output logic [31:0]            adr,
    input  logic [31:0]            dat_sm,
    input  logic                   ack,
    input  logic                   err,
    output logic                   cyc,
    output logic                   stb,
    output logic                   we,
    output logic [3:0]             sel,
    output logic [2:0]             cti,
    output logic [1:0]             bte,
    output logic                   frame_start,
    output logic                   active_buf,
    output logic                   err_flag
);

    localparam int unsigned NWORDS = HDISP * VDISP;
    localparam int unsigned WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned CW     = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, CHECK, BURST, GAP} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   w_q, w_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   len_q, len_d;
    logic            cyc_q, cyc_d;
    logic            fs_q, fs_d;
    logic            err_q, err_d;
    logic [31:0]     base_q, base_d;
    logic            buf_q, buf_d;

    logic [31:0]     remaining;
    logic [CW-1:0]   len_c;
    logic            room;
    logic            last_beat;
    logic [WW-1:0]   w_next;

`ifdef FB_DOUBLE_BUFFER_EN
    logic            pend_q, pend_d;
`else
    logic            unused_db;
    assign unused_db = ^{fb_base1, swap_req};
`endif

    assign remaining = NWORDS - 32'(w_q);
    assign len_c     = (remaining < BURST_LEN) ? CW'(remaining) : CW'(BURST_LEN);
    // Registered go/no-go: fifo_free only reaches stb through cyc_q.
    assign room      = 32'(fifo_free) >= 32'(len_c);
    assign last_beat = (cnt_q == len_q - CW'(1));
    assign w_next    = (32'(w_q) == NWORDS - 1) ? '0 : w_q + WW'(1);

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        cyc_d      = cyc_q;
        fs_d       = 1'b0;
        err_d      = err_q;
        base_d     = base_q;
        buf_d      = buf_q;
        fifo_write = 1'b0;
        fifo_wdata = 32'h0;
        cti        = 3'b000;
`ifdef FB_DOUBLE_BUFFER_EN
        pend_d     = pend_q;
`endif
        case (state_q)
            IDLE: begin
                w_d = '0;
                if (enable) state_d = CHECK;
            end
            CHECK: begin
                if (room) begin
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    len_d   = len_c;
                    state_d = BURST;
                    if (w_q == '0) begin
                        fs_d = 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
                        buf_d  = buf_q ^ pend_q;
                        pend_d = 1'b0;
                        base_d = (buf_q ^ pend_q) ? fb_base1 : fb_base0;
`else
                        base_d = fb_base0;
`endif
                    end
                end
            end
            BURST: begin
                cti = last_beat ? 3'b111 : 3'b010;
                if (ack || err) begin
                    // An errored beat still writes a word so pixels stay aligned.
                    fifo_write = 1'b1;
                    fifo_wdata = err ? 32'h0 : dat_sm;
                    if (err) err_d = 1'b1;
                    w_d   = w_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_beat) begin
                        cyc_d   = 1'b0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                state_d = enable ? CHECK : IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef FB_DOUBLE_BUFFER_EN
        // Set after the frame-start clear so a same-cycle request waits a frame.
        if (swap_req) pend_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            cyc_q   <= 1'b0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
            base_q  <= fb_base0;
            buf_q   <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            cyc_q   <= cyc_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
`ifdef FB_DOUBLE_BUFFER_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign adr         = base_q + (32'(w_q) << 2);
    assign cyc         = cyc_q;
    assign stb         = cyc_q;
    assign we          = 1'b0;
    assign sel         = 4'b1111;
    assign bte         = 2'b00;
    assign frame_start = fs_q;
    assign active_buf  = buf_q;
    assign err_flag    = err_q;

endmodule

// File: doc/fb_burst_reader.md
Name: fb_burst_reader

Overview:
- Single-clock Wishbone master that streams a framebuffer from SDRAM into a downstream pixel FIFO's write port, using classic incrementing bursts.
- Parametrised successor of the single-beat framebuffer fetch: configurable resolution, burst length and FIFO depth, and a runtime base address.
- Bursts are gated on FIFO free space, never cross a frame boundary, and the block reports frame start.
- Sits in the Wishbone clock domain, between the SDRAM controller and the async pixel FIFO.

Parameters:
- HDISP, 800, pixels (32-bit words) per line.
- VDISP, 480, lines per frame.
- BURST_LEN, 8, maximum beats per burst; power of two, 1..64.
- DEPTH_WIDTH, 8, log2 of downstream FIFO depth; sets fifo_free width.

Ports:
- clk  in  1  Wishbone clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  fetch enable.
- fb_base0  in  32  frame buffer 0 byte base address, word aligned.
- fb_base1  in  32  frame buffer 1 byte base address; used only with FB_DOUBLE_BUFFER_EN.
- swap_req  in  1  pulse requesting a buffer swap at the next frame boundary; used only with FB_DOUBLE_BUFFER_EN.
- fifo_free  in  DEPTH_WIDTH+1  free word slots in the downstream FIFO.
- fifo_write  out  1  FIFO write strobe.
- fifo_wdata  out  32  FIFO write data.
- adr  out  32  Wishbone byte address.
- dat_sm  in  32  Wishbone read data.
- ack  in  1  Wishbone acknowledge.
- err  in  1  Wishbone error.
- cyc, stb, we  out  1 each  Wishbone controls.
- sel  out  4  byte selects.
- cti  out  3  cycle type identifier.
- bte  out  2  burst type extension.
- frame_start  out  1  one-cycle pulse when word 0 of a frame is requested.
- active_buf  out  1  buffer currently being read.
- err_flag  out  1  sticky bus error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: cyc=stb=0, fifo_write=0, frame_start=0, active_buf=0, err_flag=0, word index=0, state IDLE. A reset mid-burst drops cyc/stb on the next edge with no further FIFO writes.
- Constant outputs: we=0, sel=4'b1111, bte=2'b00.
- Addressing:
  - Word index w runs 0..HDISP*VDISP-1; its width is $clog2(HDISP*VDISP).
  - adr = base + 4*w, computed in 32 bits; wrap past 2^32 is ignored.
  - base is fb_base0 or fb_base1, selected by active_buf and latched at frame start.
- FSM states: IDLE, CHECK, BURST, GAP.
- IDLE: cyc=0. Go to CHECK when enable=1.
- CHECK:
  - Compute len = min(BURST_LEN, words remaining in frame).
  - If fifo_free >= len: assert cyc/stb, enter BURST. If w==0, pulse frame_start in this same cycle.
  - Otherwise stay in CHECK with cyc=0.
- BURST:
  - cyc/stb held high.
  - cti=3'b010 for every beat except the final one, which uses 3'b111. A len=1 burst uses 3'b111 for its single beat.
  - On each ack: fifo_write=1 and fifo_wdata=dat_sm in the same cycle (combinational pass-through, zero latency); adr advances by 4 and w increments.
  - When the final beat is acked: drop cyc/stb next cycle and enter GAP.
- GAP: one idle cycle with cyc=0. Then go to CHECK if enable=1, else IDLE.
- Frame wrap: after word HDISP*VDISP-1 is acked, w returns to 0. The next CHECK begins a new frame.
- err: treated as a terminating beat.
  - fifo_write=1 with fifo_wdata=0 to preserve pixel alignment.
  - err_flag set sticky, cleared only by rst.
  - The burst continues to its planned length.
- Simultaneous ack and err: treated as err.
- enable dropped mid-burst: the burst completes, then IDLE. w resets to 0, so the next enable restarts at the frame start.
- Timing constraint: no combinational path from fifo_free to stb except through the CHECK registered decision.

Optional Feature:
- Macro: FB_DOUBLE_BUFFER_EN.
- Defined:
  - A swap_req pulse is latched into a pending flag.
  - At the next frame start (the CHECK cycle with w==0), active_buf toggles, the pending flag clears, and the new base is used from that frame onwards.
  - A swap requested in the very cycle of a frame start applies to the following frame.
- Undefined:
  - fb_base1 and swap_req are ignored; active_buf stays 0; base is always fb_base0.

Test Plan:
- Basic frame: HDISP=4, VDISP=2, BURST_LEN=4, fb_base0=0x1000, fifo_free=16, zero-wait ack -> two bursts at adr 0x1000..0x100C and 0x1010..0x101C; cti 010,010,010,111 in each; one GAP cycle between; frame_start once per frame; 8 fifo_writes.
- Short tail: HDISP=5, VDISP=1, BURST_LEN=4 -> bursts of 4 then 1; the single beat carries cti=111; the next burst is at 0x1000 with frame_start=1.
- Backpressure: fifo_free=3, BURST_LEN=4 -> cyc stays 0 indefinitely; raise fifo_free to 4 -> burst starts the next cycle.
- Wait states and error: ack delayed 3 cycles per beat, err on beat 2 -> stb held until ack; beat 2 writes 0 to the FIFO; err_flag=1 until rst; the burst still completes 4 beats.
- Reset and enable: rst asserted mid-burst -> cyc=0 next cycle and adr returns to fb_base0. enable dropped during beat 1 -> remaining beats complete, then IDLE; re-enable restarts at w=0.
- Double buffer (FB_DOUBLE_BUFFER_EN defined): fb_base1=0x8000, swap_req mid-frame -> the current frame finishes from 0x1000; the next frame reads from 0x8000 with active_buf=1.
